j1_io_arbiter: RTL and testbench

Shares the j1 Forth core's single 16-bit IO bus (rd/wr strobes, address, data) with a second requester, a host/debug port, in front of one peripheral bus. j1 accesses cannot be stalled, so they always take the bus immediately. Host accesses use a req/ack handshake and fill idle bus cycles. All peripheral-side outputs are registered. Read data returns to whichever requester issued the read.

---
 rtl/j1_io_pkg.sv | 25 ++
 rtl/j1_io_arbiter.sv | 131 +++++++++++++
 tb/tb_j1_io_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/j1_io_pkg.sv
// j1 IO arbiter shared types: host FSM states,
// read-owner encoding and default bus widths.
package j1_io_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_WR_ACK = 2'd1,
    H_RD_ISS = 2'd2,
    H_RD_ACK = 2'd3
  } h_state_e;

  localparam logic OWN_J1   = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic [15:0] lim
  );
    return (v >= lim) ? lim : v + 16'd1;
  endfunction

endpackage

// File: rtl/j1_io_arbiter.sv
// Shares the j1 IO bus with a host port; j1 never
// stalls, host fills idle cycles via req/ack.
module j1_io_arbiter
  import j1_io_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 255
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          j1_io_rd,
  input  logic          j1_io_wr,
  input  logic [AW-1:0] j1_io_addr,
  input  logic [DW-1:0] j1_io_dout,
  output logic [DW-1:0] j1_io_din,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_starve,
  output logic          per_rd,
  output logic          per_wr,
  output logic [AW-1:0] per_addr,
  output logic [DW-1:0] per_wdata,
  input  logic [DW-1:0] per_rdata
);

  localparam logic [15:0] LIM = 16'(STARVE_LIMIT);

  h_state_e    state_q;
  h_state_e    state_d;
  logic        j1_act;
  logic        j1_rd_eff;
  logic        host_pend;
  logic        grant;
  logic        blocked;
  logic        rd_owner;
  logic [15:0] starve_cnt;
  logic [15:0] cnt_inc;

  assign j1_act    = j1_io_rd | j1_io_wr;
  // a dual strobe is treated as a write only
  assign j1_rd_eff = j1_io_rd & ~j1_io_wr;
  assign host_pend = (state_q == H_IDLE) & host_req;
  assign grant     = host_pend & ~j1_act;
  assign blocked   = host_pend & j1_act;
  assign cnt_inc   = sat_inc(starve_cnt, LIM);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) state_q <= H_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      H_IDLE: begin
        if (grant)
          state_d = host_we ? H_WR_ACK : H_RD_ISS;
      end
      H_WR_ACK: state_d = H_IDLE;
      H_RD_ISS: state_d = H_RD_ACK;
      H_RD_ACK: state_d = H_IDLE;
      default:  state_d = H_IDLE;
    endcase
  end

  always_comb begin
    host_ack = (state_q == H_WR_ACK) |
               (state_q == H_RD_ACK);
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      per_rd    <= 1'b0;
      per_wr    <= 1'b0;
      per_addr  <= '0;
      per_wdata <= '0;
      rd_owner  <= OWN_J1;
    end else begin
      unique case (1'b1)
        j1_act: begin
          per_rd    <= j1_rd_eff;
          per_wr    <= j1_io_wr;
          per_addr  <= j1_io_addr;
          per_wdata <= j1_io_dout;
          rd_owner  <= OWN_J1;
        end
        grant: begin
          per_rd    <= ~host_we;
          per_wr    <= host_we;
          per_addr  <= host_addr;
          per_wdata <= host_wdata;
          rd_owner  <= OWN_HOST;
        end
        default: begin
          per_rd <= 1'b0;
          per_wr <= 1'b0;
        end
      endcase
    end
  end

  // read data follows the owner captured with per_rd
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      j1_io_din  <= '0;
      host_rdata <= '0;
    end else if (per_rd) begin
      if (rd_owner == OWN_HOST) host_rdata <= per_rdata;
      else                      j1_io_din  <= per_rdata;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      starve_cnt  <= '0;
      host_starve <= 1'b0;
    end else if (grant) begin
      starve_cnt  <= '0;
      host_starve <= 1'b0;
    end else if (blocked) begin
      starve_cnt <= cnt_inc;
      if (cnt_inc == LIM) host_starve <= 1'b1;
    end
  end

endmodule

// File: tb/tb_j1_io_arbiter.sv
// Bench for j1_io_arbiter: directed scenarios then
// random traffic against a cycle-count reference model.
module tb_j1_io_arbiter;

  localparam int LIM = 4;

  logic        clk;
  logic        sys_rst_i;
  logic        j1_io_rd;
  logic        j1_io_wr;
  logic [15:0] j1_io_addr;
  logic [15:0] j1_io_dout;
  logic [15:0] j1_io_din;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_starve;
  logic        per_rd;
  logic        per_wr;
  logic [15:0] per_addr;
  logic [15:0] per_wdata;
  logic [15:0] per_rdata;

  j1_io_arbiter #(
    .AW(16), .DW(16), .STARVE_LIMIT(LIM)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (sys_rst_i),
    .j1_io_rd   (j1_io_rd),
    .j1_io_wr   (j1_io_wr),
    .j1_io_addr (j1_io_addr),
    .j1_io_dout (j1_io_dout),
    .j1_io_din  (j1_io_din),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_starve(host_starve),
    .per_rd     (per_rd),
    .per_wr     (per_wr),
    .per_addr   (per_addr),
    .per_wdata  (per_wdata),
    .per_rdata  (per_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] pmem [256];
  assign per_rdata = per_rd ? pmem[per_addr[7:0]] : 16'hDEAD;

  typedef struct {
    int          at;
    bit          host;
    logic [15:0] val;
  } cap_t;

  int          checks;
  int          failures;
  int          cyc;
  int          host_free_at;
  int          ack_at;
  int          starve_cnt;
  logic [15:0] mem_m [256];
  cap_t        capq [$];
  logic        e_rd, e_wr, e_starve;
  logic [15:0] e_addr, e_wdata, e_din, e_hrd;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a,
                         input logic [15:0] v);
    pmem[a]  = v;
    mem_m[a] = v;
  endtask

  task automatic step(
    input logic rd, input logic wr,
    input logic [15:0] a, input logic [15:0] d,
    input logic rq, input logic we,
    input logic [15:0] ha, input logic [15:0] hd,
    input logic rs
  );
    bit   idle;
    cap_t c;
    @(negedge clk);
    if (per_wr) pmem[per_addr[7:0]] = per_wdata;
    j1_io_rd   = rd;
    j1_io_wr   = wr;
    j1_io_addr = a;
    j1_io_dout = d;
    host_req   = rq;
    host_we    = we;
    host_addr  = ha;
    host_wdata = hd;
    sys_rst_i  = rs;
    e_rd = 1'b0;
    e_wr = 1'b0;
    idle = (cyc >= host_free_at);
    if (rs) begin
      e_starve     = 1'b0;
      e_din        = '0;
      e_hrd        = '0;
      e_addr       = '0;
      starve_cnt   = 0;
      ack_at       = -1;
      host_free_at = cyc + 1;
      capq.delete();
    end else if (rd || wr) begin
      e_addr = a;
      if (wr) begin
        e_wr = 1'b1;
        e_wdata = d;
        mem_m[a[7:0]] = d;
      end else begin
        e_rd = 1'b1;
        capq.push_back('{cyc + 2, 1'b0, mem_m[a[7:0]]});
      end
      if (idle && rq) begin
        if (starve_cnt < LIM) starve_cnt++;
        if (starve_cnt == LIM) e_starve = 1'b1;
      end
    end else if (idle && rq) begin
      e_addr = ha;
      starve_cnt = 0;
      e_starve = 1'b0;
      if (we) begin
        e_wr = 1'b1;
        e_wdata = hd;
        mem_m[ha[7:0]] = hd;
        ack_at = cyc + 1;
        host_free_at = cyc + 2;
      end else begin
        e_rd = 1'b1;
        capq.push_back('{cyc + 2, 1'b1, mem_m[ha[7:0]]});
        ack_at = cyc + 2;
        host_free_at = cyc + 3;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    while (capq.size() > 0 && capq[0].at == cyc) begin
      c = capq.pop_front();
      if (c.host) e_hrd = c.val;
      else        e_din = c.val;
    end
    chk("per_rd", per_rd, e_rd);
    chk("per_wr", per_wr, e_wr);
    if (e_rd || e_wr) chk("per_addr", per_addr, e_addr);
    if (e_wr) chk("per_wdata", per_wdata, e_wdata);
    chk("j1_io_din", j1_io_din, e_din);
    chk("host_rdata", host_rdata, e_hrd);
    chk("host_ack", host_ack, ack_at == cyc);
    chk("host_starve", host_starve, e_starve);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic        h_act;
  logic        h_we;
  logic [15:0] h_a, h_d;
  logic        r_rd, r_wr, r_rs;
  int          r;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    host_free_at = 0;
    ack_at = -1;
    starve_cnt = 0;
    e_starve = 0;
    e_din = 0;
    e_hrd = 0;
    e_addr = 0;
    e_wdata = 0;
    sys_rst_i = 1'b1;
    j1_io_rd = 0; j1_io_wr = 0;
    j1_io_addr = 0; j1_io_dout = 0;
    host_req = 0; host_we = 0;
    host_addr = 0; host_wdata = 0;
    for (int i = 0; i < 256; i++)
      preload(8'(i), 16'($urandom));

    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 5, 0, 1, 0, 9, 0, 1);
    chk("rst_per_addr", per_addr, 0);
    chk("rst_per_wdata", per_wdata, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_din", j1_io_din, 0);

    step(0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 0, 0);
    chk("t1_wr", per_wr, 1);
    chk("t1_addr", per_addr, 16'h0010);
    chk("t1_wdata", per_wdata, 16'hBEEF);
    step(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
    idle_step();
    chk("t1_din", j1_io_din, 16'hBEEF);

    preload(8'h20, 16'h1234);
    step(0, 0, 0, 0, 1, 0, 16'h0020, 0, 0);
    chk("t2_per_rd", per_rd, 1);
    chk("t2_no_ack", host_ack, 0);
    step(0, 0, 0, 0, 1, 0, 16'h0020, 0, 0);
    chk("t2_ack", host_ack, 1);
    chk("t2_rdata", host_rdata, 16'h1234);
    chk("t2_din_held", j1_io_din, 16'hBEEF);
    idle_step();

    step(0, 1, 16'h50, 16'h1111, 1, 1, 16'h60, 16'hCAFE, 0);
    step(0, 1, 16'h51, 16'h2222, 1, 1, 16'h60, 16'hCAFE, 0);
    chk("t3_order", per_addr, 16'h0051);
    step(0, 1, 16'h52, 16'h3333, 1, 1, 16'h60, 16'hCAFE, 0);
    chk("t3_noack", host_ack, 0);
    step(0, 0, 0, 0, 1, 1, 16'h60, 16'hCAFE, 0);
    chk("t3_ack", host_ack, 1);
    chk("t3_haddr", per_addr, 16'h0060);
    idle_step();

    preload(8'h30, 16'hAAAA);
    preload(8'h31, 16'h5555);
    step(0, 0, 0, 0, 1, 0, 16'h30, 0, 0);
    step(1, 0, 16'h31, 0, 1, 0, 16'h30, 0, 0);
    chk("t4_hrd", host_rdata, 16'hAAAA);
    idle_step();
    chk("t4_din", j1_io_din, 16'h5555);
    chk("t4_hrd_held", host_rdata, 16'hAAAA);

    for (int i = 0; i < 10; i++) begin
      step(1, 0, 16'(i), 0, 1, 0, 16'h70, 0, 0);
      if (i == 2) chk("t5_not_yet", host_starve, 0);
      if (i == 3) chk("t5_starve", host_starve, 1);
    end
    step(0, 0, 0, 0, 1, 0, 16'h70, 0, 0);
    chk("t5_clear", host_starve, 0);
    step(0, 0, 0, 0, 1, 0, 16'h70, 0, 0);
    idle_step();

    step(0, 0, 0, 0, 1, 0, 16'h20, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t6_ack", host_ack, 0);
    chk("t6_rd", per_rd, 0);
    chk("t6_hrd", host_rdata, 0);
    chk("t6_din", j1_io_din, 0);
    idle_step();
    chk("t6_ack2", host_ack, 0);

    step(1, 1, 16'h40, 16'h7777, 0, 0, 0, 0, 0);
    chk("t7_wr", per_wr, 1);
    chk("t7_rd", per_rd, 0);
    idle_step();
    chk("t7_din", j1_io_din, 0);
    step(1, 0, 16'h40, 0, 0, 0, 0, 0, 0);
    idle_step();
    chk("t7_rdback", j1_io_din, 16'h7777);

    h_act = 0;
    h_we = 0;
    h_a = 0;
    h_d = 0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 9));
      r_rd = (r >= 4 && r <= 6) || r == 9;
      r_wr = (r >= 7);
      r_rs = ($urandom_range(0, 299) == 0);
      if (h_act && ack_at == cyc) begin
        h_act = 0;
      end else if (!h_act && $urandom_range(0, 2) == 0) begin
        h_act = 1;
        h_we = 1'($urandom);
        h_a = 16'($urandom_range(0, 15));
        h_d = 16'($urandom);
      end
      step(r_rd, r_wr, 16'($urandom_range(0, 15)),
           16'($urandom), h_act, h_we, h_a, h_d, r_rs);
      chk("excl", per_rd & per_wr, 0);
      if (r_rs) h_act = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
